// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux4_rr_arbiter_if                                                       |
// | Requester-side and consumer-side bundle for the 4:1 round-robin arbiter. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface mux4_rr_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]      req;
  logic [3:0]      last;
  logic [4*DW-1:0] din;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;

  modport master (
    output req, last, din, out_ready,
    input  gnt, sel, out_valid, out_data, out_src
  );

  modport slave (
    input  req, last, din, out_ready,
    output gnt, sel, out_valid, out_data, out_src
  );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux4_rr_arbiter                                                          |
// | Round-robin arbiter driving a 4:1 select into one registered valid/ready |
// | output stage. Define MUX4_ARB_LOCK_EN for burst lock mode.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mux4_rr_arbiter #(
  parameter int DW = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_FREE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    r_state;
  logic [1:0]    r_ptr;
  logic [1:0]    r_owner;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [1:0]    r_out_src;

  logic [DW-1:0] w_words [4];
  logic [3:0]    w_elig;
  logic [1:0]    w_choice;
  logic [1:0]    w_idx;
  logic          w_found;
  logic          w_space;
  logic          w_accept;

  for (genvar k = 0; k < 4; k++) begin : g_words
    assign w_words[k] = bus.din[k*DW +: DW];
  end

  always_comb begin
    w_elig = bus.req;
    if (r_state == ST_LOCKED) begin
      w_elig = bus.req & (4'b0001 << r_owner);
    end
  end

  // Scan from the pointer; with nothing eligible the select parks on ptr.
  always_comb begin
    w_found  = 1'b0;
    w_choice = r_ptr;
    w_idx    = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_choice = w_idx;
      end
    end
  end

  assign w_space  = !r_out_valid || bus.out_ready;
  assign w_accept = rst_n && w_space && w_found;

  assign bus.gnt       = w_accept ? (4'b0001 << w_choice) : 4'b0000;
  assign bus.sel       = w_choice;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 2'd0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_words[w_choice];
      r_out_src   <= w_choice;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FREE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
    end else if (w_accept) begin
`ifdef MUX4_ARB_LOCK_EN
      // A non-final word pins ownership and freezes rotation until last.
      if (bus.last[w_choice]) begin
        r_state <= ST_FREE;
        r_ptr   <= w_choice + 2'd1;
      end else begin
        r_state <= ST_LOCKED;
        r_owner <= w_choice;
      end
`else
      r_ptr <= w_choice + 2'd1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for one shared 4:1 selection path (AL_MAP_MUX4-style, 2-bit select). It takes up to four requesters with independent valid/data, decides each cycle which one owns the mux, drives the select, and registers the chosen word into a single valid/ready output stage. It sits between four producer channels and one downstream consumer.

## Interface
- DW, 8, data width per requester word.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per requester k; req[k]=1 means din word k is valid.
- last  in  4  last-of-burst flag per requester; used only when lock mode is compiled in.
- din  in  4*DW  requester words; word k occupies din[k*DW +: DW].
- gnt  out  4  one-hot accept strobe, combinational; gnt[k]=1 means word k is consumed at this edge.
- sel  out  2  mux select; index of the current choice.
- out_valid  out  1  output register holds a word.
- out_data  out  DW  registered selected word.
- out_src  out  2  index of the requester that supplied out_data.
- out_ready  in  1  downstream accepts out_data when out_valid=1 at this edge.

## Operation
- Round-robin pointer ptr[1:0] marks the highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- choice = first index in search order with req set and eligible. If no requester is eligible, sel=ptr.
- space = !out_valid || out_ready.
- accept = space && any eligible req. On accept, gnt[choice]=1; otherwise gnt=0.
- On accept at the edge: out_data<=din[choice], out_src<=choice, out_valid<=1.
- Without accept, if out_ready && out_valid: out_valid<=0.
- Otherwise out_data, out_src and out_valid hold.
- Pointer update on accept: ptr<=choice+1 (wraps 3->0), except as modified by lock mode.
- FSM has two states: FREE and LOCKED. Without the macro, only FREE is reachable.
  - FREE: all requesters are eligible.
  - LOCKED: only the owner owner[1:0] is eligible.
- req[k] dropped mid-burst while LOCKED: the arbiter stays LOCKED and produces no grants until req[owner] returns.

## Timing
- Latency is one cycle: gnt at edge n gives out_valid=1 with the word after edge n.
- Throughput is one word per cycle when out_ready stays high. A simultaneous drain and load at one edge is a load (out_valid stays 1).
- When out_valid=1 and out_ready=0: gnt=0, and out_data/out_src are stable until the edge where ready is seen.
- gnt and sel depend combinationally on req, last state, ptr and out_ready; there are no combinational paths from din.
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0, owner=0, state FREE, so gnt=0 and sel=0 while req=0.
- Reset asserted mid-burst or mid-transfer: all of the above return immediately, and any pending word is discarded.

## Configuration
- MUX4_ARB_LOCK_EN defined (lock mode):
  - An accept of choice with last[choice]=0 enters LOCKED with owner=choice and leaves ptr unchanged.
  - An accept with last[choice]=1 returns to FREE and sets ptr<=choice+1.
  - A single-word burst (last=1 on the first word) behaves as in word mode.
- MUX4_ARB_LOCK_EN undefined (word mode): last is ignored, the FSM is always FREE, and ptr advances on every accept.

## Test plan
- Reset check: hold rst_n=0 with req=4'hF and out_ready=1. Required: gnt=0, out_valid=0, out_data=0, sel=0. First edge after release: gnt=4'b0001.
- Fairness, word mode: req=4'hF, out_ready=1, din words 0xA0..0xA3 for requesters 0..3. Required: out_src sequence 0,1,2,3,0,1, out_data 0xA0,0xA1,0xA2,0xA3,0xA0, one word per cycle.
- Backpressure: out_valid=1, out_data=0x55, out_ready=0 for 3 cycles, req=4'b0100. Required: gnt=0 and out_data=0x55 stable. The cycle out_ready rises: gnt=4'b0100, and 0x66 from requester 2 appears next cycle.
- Sparse wrap: ptr=3, req=4'b0010. Required: gnt=4'b0010, then ptr=2. Next, req=4'b1001. Required: gnt=4'b1000.
- Lock mode (MUX4_ARB_LOCK_EN): req0 burst of 3 words with last on the third; req1 held high throughout. Required: out_src 0,0,0,1. A req0 gap of 2 cycles mid-burst gives gnt=0 for those 2 cycles, and requester 1 is not granted.
- Reset mid-burst (MUX4_ARB_LOCK_EN): rst_n pulsed low after word 2 of a 3-word burst from requester 3, with req=4'b1010. Required: out_valid=0 immediately. After release: gnt=4'b0010 (ptr=0, state FREE).
